// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's three channels.
//   imem request  : imem_req_valid/imem_req_addr out, imem_req_ready in
//   imem response : imem_resp_valid/imem_resp_data in (in order, >=1 cycle)
//   redirect      : redirect_valid/redirect_pc in
//   decode side   : instr_valid/instr_data/instr_pc out, instr_ready in
// master = the fetch unit, slave = memory + decode environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_data, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_data, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues sequential word reads to instruction memory,
// buffers returned words with their PCs in an in-order prefetch FIFO and
// hands them to decode over valid/ready. A redirect flushes the FIFO and
// marks every in-flight read for discard, then restarts at the new PC.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master (imem request/response, redirect, decode)
// Parameters:
//   RESET_PC - first fetch address after reset (word aligned)
//   DEPTH    - FIFO entries = credit limit on outstanding + buffered words
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;

  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          head_valid;

  // Credit check uses only registered counters, so request issue never
  // depends combinationally on decode ready or on a response this cycle.
  assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign req_valid   = !rst && !bus.redirect_valid
                       && (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;

  assign head_valid  = !rst && (cnt_q != '0);
  assign pop         = head_valid && bus.instr_ready;

  // Words from before a redirect are dropped while the discard counter
  // drains; a response coinciding with a redirect is dropped as well.
  assign push        = bus.imem_resp_valid && !bus.redirect_valid
                       && (disc_q == '0);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr_data     = head_valid ? fifo_data_q[rd_q] : 32'h0;
  assign bus.instr_pc       = head_valid ? fifo_pc_q[rd_q]   : 32'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    out_d      = out_q + CW'(req_fire) - CW'(bus.imem_resp_valid);

    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      // Everything still in flight after this cycle must be thrown away.
      disc_d     = out_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (bus.imem_resp_valid && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_d      = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  // FIFO storage needs no reset; the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_q]   <= resp_pc_q;
      fifo_data_q[wr_q] <= bus.imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // memory model: in-order responses, per-request latency
  typedef struct {
    logic [31:0] addr;
    int          due;
  } ent_t;
  ent_t        mq[$];
  int          cyc       = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          max_out   = 0;
  int          delivered = 0;
  logic [31:0] exp_pc    = 32'h0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      exp_pc    = 32'h0;
      hold_pend = 1'b0;
    end else begin
      if (bus.instr_valid && bus.instr_ready) begin
        check("pop_pc", bus.instr_pc, exp_pc);
        check("pop_data", bus.instr_data, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (hold_pend && !bus.redirect_valid) begin
        check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
        check("req_hold_addr", bus.imem_req_addr, hold_addr);
      end
      hold_pend = bus.imem_req_valid && !bus.imem_req_ready;
      hold_addr = bus.imem_req_addr;
      if (bus.redirect_valid) exp_pc = {bus.redirect_pc[31:2], 2'b00};
      if (bus.imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready)
        mq.push_back('{addr: bus.imem_req_addr,
                       due: cyc + int'($urandom_range(lat_max, lat_min))});
      if (mq.size() > max_out) max_out = mq.size();
    end
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      bus.imem_resp_valid <= 1'b1;
      bus.imem_resp_data  <= word_of(mq[0].addr);
    end else begin
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data  <= 32'h0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int lat);
    @(negedge clk);
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b1;
    bus.imem_req_ready = 1'b1;
    lat_min            = lat;
    lat_max            = lat;
    step();
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_instr(string tag, logic [31:0] pc);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.instr_valid) break;
    end
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_pc"}, bus.instr_pc, pc);
    check({tag, "_data"}, bus.instr_data, word_of(pc));
  endtask

  initial begin
    int seg_start;

    // reset values
    do_reset(1);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_instr_data", bus.instr_data, 32'h0);

    // 1: sequential fetch, latency N -> N+2
    do_reset(1);
    step();
    check("t1_e0_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("t1_e0_req_addr", bus.imem_req_addr, 32'h4);
    step();
    check("t1_e1_instr_valid", 32'(bus.instr_valid), 32'd1);
    check("t1_e1_pc", bus.instr_pc, 32'h0);
    check("t1_e1_data", bus.instr_data, word_of(32'h0));
    expect_instr("t1_4", 32'h4);
    expect_instr("t1_8", 32'h8);
    expect_instr("t1_c", 32'hC);

    // 2: decode stall fills exactly DEPTH entries
    @(negedge clk);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("t2_stall_valid", 32'(bus.instr_valid), 32'd1);
    check("t2_stall_pc", bus.instr_pc, 32'hC);
    check("t2_stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t2_stall_req_addr", bus.imem_req_addr, 32'h14);
    @(negedge clk);
    bus.instr_ready = 1'b1;
    step();
    check("t2_second_pc", bus.instr_pc, 32'h10);
    check("t2_resume_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t2_resume_req_addr", bus.imem_req_addr, 32'h14);
    step();
    check("t2_drained_valid", 32'(bus.instr_valid), 32'd0);
    expect_instr("t2_14", 32'h14);
    expect_instr("t2_18", 32'h18);

    // 3: redirect with two reads in flight
    do_reset(4);
    step();
    check("t3_e0_req_addr", bus.imem_req_addr, 32'h4);
    step();
    check("t3_credit_full", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #1;
    check("t3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    check("t3_post_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("t3_post_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t3_post_req_addr", bus.imem_req_addr, 32'h100);
    expect_instr("t3_100", 32'h100);
    expect_instr("t3_104", 32'h104);

    // 3b: redirect with one word buffered and one read in flight
    do_reset(1);
    bus.instr_ready = 1'b0;
    step();
    @(negedge clk);
    lat_min = 5;
    lat_max = 5;
    step();
    check("t3b_buffered_pc", bus.instr_pc, 32'h0);
    check("t3b_credit_full", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b1;
    lat_min            = 1;
    lat_max            = 1;
    #1;
    check("t3b_flushed", 32'(bus.instr_valid), 32'd0);
    check("t3b_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t3b_req_addr", bus.imem_req_addr, 32'h200);
    expect_instr("t3b_200", 32'h200);
    expect_instr("t3b_204", 32'h204);

    // 4: redirect coinciding with a response and a pop
    do_reset(1);
    step();
    step();
    check("t4_head_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    check("t4_flushed", 32'(bus.instr_valid), 32'd0);
    check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t4_req_addr", bus.imem_req_addr, 32'h300);
    expect_instr("t4_300", 32'h300);
    expect_instr("t4_304", 32'h304);

    // 4b: back-to-back redirects, last one wins
    do_reset(4);
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    step();
    @(negedge clk);
    bus.redirect_pc    = 32'h0000_0502;
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    check("t4b_req_addr", bus.imem_req_addr, 32'h500);
    expect_instr("t4b_500", 32'h500);
    expect_instr("t4b_504", 32'h504);

    // 6: PC wrap
    do_reset(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF9;
    step();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    expect_instr("t6_fff8", 32'hFFFF_FFF8);
    expect_instr("t6_fffc", 32'hFFFF_FFFC);
    expect_instr("t6_0", 32'h0000_0000);

    // 5: random memory stalls, latency, decode stalls and redirects
    do_reset(1);
    lat_min   = 1;
    lat_max   = 4;
    max_out   = 0;
    seg_start = delivered;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.instr_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 59) == 0);
      bus.redirect_pc    = $urandom & 32'h000F_FFFF;
    end
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    total++;
    assert (max_out <= DEPTH) else begin
      bad++;
      $error("FAIL t5_outstanding: got %0d want <= %0d", max_out, DEPTH);
    end
    total++;
    assert (delivered - seg_start >= 500) else begin
      bad++;
      $error("FAIL t5_progress: got %0d want >= 500", delivered - seg_start);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
